// File: rtl/dec_scan_seq_pkg.sv
// Shared encodings and helpers for the scanning one-hot decoder.
package dec_scan_seq_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DIRECT = 2'd1;
    localparam logic [1:0] ST_SCAN   = 2'd2;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Ceiling log2 for elaboration-time sizing; clog2(1) is 0.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dec_scan_seq_onehot.sv
// Combinational binary-to-one-hot expander (active-high).
module dec_onehot #(
    parameter int IN_W = 3
) (
    input  logic [IN_W-1:0]      sel_i,
    output logic [(1<<IN_W)-1:0] onehot_o
);
    localparam int OUT_W = 1 << IN_W;

    assign onehot_o = {{(OUT_W-1){1'b0}}, 1'b1} << sel_i;

endmodule

// File: rtl/dec_scan_seq.sv
// Registered one-hot decoder with DIRECT and auto-stepping SCAN modes.
module dec_scan_seq
    import dec_scan_seq_pkg::*;
#(
    parameter int IN_W       = 3,
    parameter int DWELL      = 4,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 mode,
    input  logic [IN_W-1:0]      in,
    output logic [(1<<IN_W)-1:0] out,
    output logic [IN_W-1:0]      idx,
    output logic                 wrap
);
    localparam int OUT_W = 1 << IN_W;
    localparam int CNT_W = (clog2(DWELL) < 1) ? 1 : clog2(DWELL);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL - 1);
    localparam logic [IN_W-1:0]  IDX_MAX = {IN_W{1'b1}};

    logic [1:0]       state_q, state_d;
    logic [IN_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic [OUT_W-1:0] onehot;

    always_comb begin
        state_d = ST_IDLE;
        if (en) state_d = (mode == MODE_SCAN) ? ST_SCAN : ST_DIRECT;
    end

    always_comb begin
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        case (state_d)
            ST_DIRECT: begin
                idx_d = in;
                cnt_d = '0;
            end
            ST_SCAN: begin
                // Coming from DIRECT loads the start index; coming from IDLE resumes.
                if (state_q == ST_DIRECT) begin
                    idx_d = in;
                    cnt_d = '0;
                end else if (state_q == ST_SCAN) begin
                    if (cnt_q == CNT_MAX) begin
                        cnt_d  = '0;
                        idx_d  = idx_q + 1'b1;
                        wrap_d = (idx_q == IDX_MAX);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    dec_onehot #(.IN_W(IN_W)) u_onehot (
        .sel_i    (idx_d),
        .onehot_o (onehot)
    );

    always_comb begin
        out_d = (state_d == ST_IDLE) ? '0 : onehot;
        if (ACTIVE_LOW) out_d = ~out_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
            out_q   <= ACTIVE_LOW ? '1 : '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
            out_q   <= out_d;
        end
    end

    assign out  = out_q;
    assign idx  = idx_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_dec_scan_seq.sv
// Directed scoreboard bench: default decoder plus an active-low, DWELL=1 variant.
module tb_dec_scan_seq;

    typedef struct {
        logic [7:0] o;
        logic [2:0] i;
        logic       w;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_a, en_a, mode_a;
    logic [2:0] in_a;
    logic [7:0] out_a;
    logic [2:0] idx_a;
    logic       wrap_a;
    logic       rst_b, en_b, mode_b;
    logic [2:0] in_b;
    logic [7:0] out_b;
    logic [2:0] idx_b;
    logic       wrap_b;

    exp_t qa[$];
    exp_t qb[$];
    int   n_asrt = 0;
    int   n_fail = 0;
    int   stepn  = 0;

    always #5 clk = ~clk;

    dec_scan_seq #(.IN_W(3), .DWELL(4), .ACTIVE_LOW(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_a), .en(en_a), .mode(mode_a), .in(in_a),
        .out(out_a), .idx(idx_a), .wrap(wrap_a)
    );

    dec_scan_seq #(.IN_W(3), .DWELL(1), .ACTIVE_LOW(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_b), .en(en_b), .mode(mode_b), .in(in_b),
        .out(out_b), .idx(idx_b), .wrap(wrap_b)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_asrt++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s step %0d: got %h expected %h", tag, stepn, got, exp);
        end
    endtask

    task automatic ea(input logic [7:0] o, input logic [2:0] i, input logic w);
        exp_t e;
        e.o = o; e.i = i; e.w = w;
        qa.push_back(e);
    endtask

    task automatic eb(input logic [7:0] o, input logic [2:0] i, input logic w);
        exp_t e;
        e.o = o; e.i = i; e.w = w;
        qb.push_back(e);
    endtask

    // Advance one clock and retire every expectation queued for this edge.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        stepn++;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            chk("a_out",  out_a,          e.o);
            chk("a_idx",  {5'd0, idx_a},  {5'd0, e.i});
            chk("a_wrap", {7'd0, wrap_a}, {7'd0, e.w});
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            chk("b_out",  out_b,          e.o);
            chk("b_idx",  {5'd0, idx_b},  {5'd0, e.i});
            chk("b_wrap", {7'd0, wrap_b}, {7'd0, e.w});
        end
    endtask

    task automatic hold_a(input int n, input logic [7:0] o, input logic [2:0] i);
        for (int k = 0; k < n; k++) begin
            ea(o, i, 1'b0);
            tick();
        end
    endtask

    initial begin
        rst_a = 1'b0; en_a = 1'b1; mode_a = 1'b0; in_a = 3'd5;
        rst_b = 1'b0; en_b = 1'b1; mode_b = 1'b1; in_b = 3'd0;

        // Reset dominates the enabled DIRECT inputs.
        hold_a(2, 8'h00, 3'd0);
        rst_a = 1'b1;

        // DIRECT sweep, then disable.
        for (int v = 0; v < 8; v++) begin
            in_a = 3'(v);
            ea(8'h01 << v, 3'(v), 1'b0);
            tick();
        end
        en_a = 1'b0;
        hold_a(1, 8'h00, 3'd7);

        // Load at 6 from DIRECT, dwell four cycles per index, wrap through 0.
        en_a = 1'b1; in_a = 3'd6;
        hold_a(1, 8'h40, 3'd6);
        mode_a = 1'b1;
        hold_a(1, 8'h40, 3'd6);
        in_a = 3'd1;
        hold_a(3, 8'h40, 3'd6);
        hold_a(4, 8'h80, 3'd7);
        ea(8'h01, 3'd0, 1'b1);
        tick();
        hold_a(3, 8'h01, 3'd0);
        hold_a(4, 8'h02, 3'd1);
        hold_a(4, 8'h04, 3'd2);
        hold_a(3, 8'h08, 3'd3);

        // Pause on idx 3 with its dwell count at 2; mode wiggles while disabled.
        en_a = 1'b0;
        hold_a(2, 8'h00, 3'd3);
        mode_a = 1'b0;
        hold_a(1, 8'h00, 3'd3);
        mode_a = 1'b1;
        hold_a(1, 8'h00, 3'd3);
        en_a = 1'b1;
        hold_a(2, 8'h08, 3'd3);
        hold_a(4, 8'h10, 3'd4);
        hold_a(2, 8'h20, 3'd5);

        // Reset mid-scan, then scanning restarts at index 0.
        rst_a = 1'b0;
        hold_a(1, 8'h00, 3'd0);
        rst_a = 1'b1;
        hold_a(4, 8'h01, 3'd0);
        hold_a(1, 8'h02, 3'd1);

        // Back to DIRECT from SCAN.
        mode_a = 1'b0; in_a = 3'd7;
        hold_a(1, 8'h80, 3'd7);

        // Active-low, single-cycle dwell variant.
        eb(8'hFF, 3'd0, 1'b0);
        tick();
        rst_b = 1'b1;
        for (int v = 0; v < 8; v++) begin
            eb(~(8'h01 << v), 3'(v), 1'b0);
            tick();
        end
        eb(8'hFE, 3'd0, 1'b1);
        tick();
        eb(8'hFD, 3'd1, 1'b0);
        tick();
        en_b = 1'b0;
        eb(8'hFF, 3'd1, 1'b0);
        tick();
        en_b = 1'b1;
        eb(8'hFD, 3'd1, 1'b0);
        tick();
        rst_b = 1'b0;
        eb(8'hFF, 3'd0, 1'b0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
